contrast_pipe: RTL

//   Streaming per-pixel contrast/brightness stage for the RGB pixel path, with CHANNELS channels per beat.
//   y = clamp(round((x - MID) * gain) + MID + offset), where MID = 2^(DATA_W-1).
//   2-stage pipeline with valid/ready handshake.

---
 rtl/contrast_if.sv | 29 ++
 rtl/contrast_pipe.sv | 112 +++++++++++
 2 files changed

// File: rtl/contrast_if.sv
// Pixel stream bundle for the contrast stage: gain/offset request, input and output beat channels.
interface contrast_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned GAIN_W   = 10
);
  logic [GAIN_W-1:0]          gain_in;
  logic signed [DATA_W:0]     offset_in;
  logic                       s_valid;
  logic                       s_ready;
  logic                       s_sof;
  logic [CHANNELS*DATA_W-1:0] s_data;
  logic                       m_valid;
  logic                       m_ready;
  logic                       m_sof;
  logic [CHANNELS*DATA_W-1:0] m_data;

  // Upstream source and downstream sink seen as one agent.
  modport master (
    output gain_in, offset_in, s_valid, s_sof, s_data, m_ready,
    input  s_ready, m_valid, m_sof, m_data
  );

  // The contrast stage itself.
  modport slave (
    input  gain_in, offset_in, s_valid, s_sof, s_data, m_ready,
    output s_ready, m_valid, m_sof, m_data
  );
endinterface

// File: rtl/contrast_pipe.sv
// Two-stage contrast/brightness pipeline: y = clamp(round((x - MID) * gain) + MID + offset).
// Gain/offset are latched on start-of-frame beats so a frame never sees a mid-frame change.
module contrast_pipe #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CHANNELS  = 3,
  parameter int unsigned GAIN_W    = 10,
  parameter int unsigned GAIN_FRAC = 7
) (
  input logic       clk,
  input logic       rst,
  contrast_if.slave bus
);
  localparam int unsigned PW = DATA_W + GAIN_W + 2;
  localparam logic [GAIN_W-1:0]      UnityGain = GAIN_W'(1 << GAIN_FRAC);
  localparam logic signed [DATA_W:0] MidD      = (DATA_W + 1)'(2 ** (DATA_W - 1));
  localparam logic signed [PW-1:0]   RoundC    = PW'(2 ** (GAIN_FRAC - 1));
  localparam logic signed [PW:0]     MidY      = (PW + 1)'(2 ** (DATA_W - 1));
  localparam logic signed [PW:0]     MaxY      = (PW + 1)'(2 ** DATA_W - 1);

  logic                   en1, en2;
  logic                   sof_beat;
  logic [GAIN_W-1:0]      gain_sel;
  logic signed [DATA_W:0] off_sel;

  logic [GAIN_W-1:0]      gain_q;
  logic signed [DATA_W:0] offset_q;
  logic                   v1_q, v2_q;
  logic                   sof1_q;
  logic signed [DATA_W:0] off1_q;
  logic signed [PW-1:0]   p_q [CHANNELS];
  logic signed [PW-1:0]   p_d [CHANNELS];
  logic [CHANNELS*DATA_W-1:0] m_data_q, m_data_d;
  logic                   m_sof_q;

  logic signed [DATA_W:0] d_s   [CHANNELS];
  logic signed [PW-1:0]   g_ext;
  logic signed [PW-1:0]   sum_s [CHANNELS];
  logic signed [PW-1:0]   q_s   [CHANNELS];
  logic signed [PW:0]     y_s   [CHANNELS];

  assign en2 = !v2_q | bus.m_ready;
  assign en1 = !v1_q | en2;

  assign bus.s_ready = en1;
  assign bus.m_valid = v2_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_sof   = m_sof_q;

  // An sof beat uses the freshly requested gain/offset rather than the latched ones.
  assign sof_beat = bus.s_valid & bus.s_sof;
  assign gain_sel = sof_beat ? bus.gain_in : gain_q;
  assign off_sel  = sof_beat ? bus.offset_in : offset_q;
  assign g_ext    = PW'($signed({1'b0, gain_sel}));

  // Stage 1 datapath: centre each channel on MID and scale by gain.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      d_s[c] = $signed({1'b0, bus.s_data[c*DATA_W +: DATA_W]}) - MidD;
      p_d[c] = PW'(d_s[c]) * g_ext;
    end
  end

  // Stage 2 datapath: round half up, re-centre, add offset and clamp each channel independently.
  always_comb begin
    m_data_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_s[c] = p_q[c] + RoundC;
      q_s[c]   = sum_s[c] >>> GAIN_FRAC;
      y_s[c]   = (PW + 1)'(q_s[c]) + MidY + (PW + 1)'(off1_q);
      if (y_s[c] < 0) begin
        m_data_d[c*DATA_W +: DATA_W] = '0;
      end else if (y_s[c] > MaxY) begin
        m_data_d[c*DATA_W +: DATA_W] = '1;
      end else begin
        m_data_d[c*DATA_W +: DATA_W] = y_s[c][DATA_W-1:0];
      end
    end
  end

  // Pipeline registers, frame-latched parameters and the valid/ready chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      gain_q   <= UnityGain;
      offset_q <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      sof1_q   <= 1'b0;
      off1_q   <= '0;
      m_data_q <= '0;
      m_sof_q  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        p_q[c] <= '0;
      end
    end else begin
      if (en1 && sof_beat) begin
        gain_q   <= bus.gain_in;
        offset_q <= bus.offset_in;
      end
      if (en1) begin
        v1_q   <= bus.s_valid;
        sof1_q <= bus.s_sof;
        off1_q <= off_sel;
        p_q    <= p_d;
      end
      if (en2) begin
        v2_q     <= v1_q;
        m_data_q <= m_data_d;
        m_sof_q  <= sof1_q;
      end
    end
  end
endmodule
